// File: rtl/vga_display_controller.sv
// Raster timing generator with warm-up blanking and frame-synchronous force-black.
// Every output is registered from the next (h,v), so outputs line up with the counters. There is no backpressure.
module vga_display_controller #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter bit          SYNC_POL     = 1'b0,
  parameter int unsigned BLANK_FRAMES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       force_black_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       dena_o,
  output logic       black_flag_o,
  output logic [9:0] pixel_x_o,
  output logic [9:0] pixel_y_o,
  output logic       line_start_o,
  output logic       frame_start_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);
  localparam int unsigned FW      = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FW-1:0] F_LAST = FW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t        state_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [FW-1:0] fcnt_q;
  logic          black_q;
  logic          hsync_q, vsync_q, dena_q, line_start_q, frame_start_q;
  logic [9:0]    pixel_x_q, pixel_y_q;

  logic       h_last, frame_end, active_d;
  logic       dena_d, hsync_d, vsync_d, line_start_d, frame_start_d;
  logic [9:0] pixel_x_d, pixel_y_d;

  assign h_last    = (h_q == H_LAST);
  assign frame_end = h_last && (v_q == V_LAST);

  // The cycle after an IDLE->active edge shows (0,0), so counters only advance once already running.
  always_comb begin
    h_d      = '0;
    v_d      = '0;
    active_d = enable_i;
    if (enable_i && (state_q != S_IDLE)) begin
      h_d = h_last ? '0 : h_q + HW'(1);
      v_d = v_q;
      if (h_last) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end
    end
  end

  always_comb begin
    dena_d        = active_d && (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d       = (active_d && (h_d >= HS_BEG) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (active_d && (v_d >= VS_BEG) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = active_d && (h_d == '0);
    frame_start_d = line_start_d && (v_d == '0);
    pixel_x_d     = dena_d ? 10'(h_d) : 10'd0;
    pixel_y_d     = dena_d ? 10'(v_d) : 10'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      fcnt_q        <= '0;
      black_q       <= 1'b1;
      dena_q        <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      dena_q        <= dena_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      if (!enable_i) begin
        state_q <= S_IDLE;
        fcnt_q  <= '0;
        black_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            fcnt_q <= '0;
            // With no warm-up the enable edge is itself the first frame boundary.
            if (BLANK_FRAMES == 0) begin
              state_q <= S_RUN;
              black_q <= force_black_i;
            end else begin
              state_q <= S_WARMUP;
            end
          end
          S_WARMUP: begin
            if (frame_end) begin
              fcnt_q <= fcnt_q + FW'(1);
              if (fcnt_q == F_LAST) begin
                state_q <= S_RUN;
                black_q <= force_black_i;
              end
            end
          end
          S_RUN: begin
            if (frame_end) begin
              black_q <= force_black_i;
            end
          end
          default: begin
            state_q <= S_IDLE;
            black_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign dena_o        = dena_q;
  assign black_flag_o  = black_q;
  assign pixel_x_o     = pixel_x_q;
  assign pixel_y_o     = pixel_y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_display_controller.sv
// Scoreboard bench for vga_display_controller on a reduced 16x10 raster (160 clocks per frame).
module tb_vga_display_controller;

  localparam int HT = 16;
  localparam int VT = 10;
  localparam int FT = 160;
  localparam int BF = 2;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       bf;
    logic       ls;
    logic       fs;
    logic [9:0] px;
    logic [9:0] py;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic       force_black_i;
  logic       hsync_o;
  logic       vsync_o;
  logic       dena_o;
  logic       black_flag_o;
  logic [9:0] pixel_x_o;
  logic [9:0] pixel_y_o;
  logic       line_start_o;
  logic       frame_start_o;

  always #5 clk = ~clk;

  vga_display_controller #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .BLANK_FRAMES(BF)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .force_black_i(force_black_i),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .dena_o       (dena_o),
    .black_flag_o (black_flag_o),
    .pixel_x_o    (pixel_x_o),
    .pixel_y_o    (pixel_y_o),
    .line_start_o (line_start_o),
    .frame_start_o(frame_start_o)
  );

  out_t  exp_q[$];
  string tag_q[$];
  int    t_q[$];

  int   total   = 0;
  int   bad     = 0;
  int   fs_seen = 0;
  bit   run     = 1'b0;
  int   t       = 0;
  logic blk     = 1'b1;

  function automatic out_t idle_out();
    out_t o;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    o.bf = 1'b1;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic e, input logic f, input string tag);
    out_t o;
    int   h;
    int   v;
    @(negedge clk);
    rst_i         = r;
    enable_i      = e;
    force_black_i = f;
    if (r || !e) begin
      run = 1'b0;
      o   = idle_out();
    end else begin
      if (!run) begin
        run = 1'b1;
        t   = 0;
        blk = 1'b1;
      end else begin
        t++;
      end
      h = t % HT;
      v = (t / HT) % VT;
      if ((t / FT) >= BF && (t % FT) == 0) blk = f;
      o.de = (h < 8) && (v < 6);
      o.hs = !(h >= 10 && h <= 12);
      o.vs = !(v == 7 || v == 8);
      o.bf = blk;
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
      o.px = o.de ? 10'(h) : 10'd0;
      o.py = o.de ? 10'(v) : 10'd0;
    end
    exp_q.push_back(o);
    tag_q.push_back(tag);
    t_q.push_back(run ? t : -1);
  endtask

  task automatic run_n(input int n, input logic r, input logic e, input logic f, input string tag);
    for (int i = 0; i < n; i++) step(r, e, f, tag);
  endtask

  initial begin
    out_t  ex;
    out_t  ac;
    string tg;
    int    tt;
    forever begin
      @(posedge clk);
      #1;
      if (frame_start_o === 1'b1) fs_seen++;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        tg = tag_q.pop_front();
        tt = t_q.pop_front();
        ac = '{hsync_o, vsync_o, dena_o, black_flag_o, line_start_o, frame_start_o,
               pixel_x_o, pixel_y_o};
        total++;
        if (ac !== ex) begin
          bad++;
          $display("FAIL %s t=%0d got hs=%b vs=%b de=%b bf=%b ls=%b fs=%b x=%0d y=%0d want hs=%b vs=%b de=%b bf=%b ls=%b fs=%b x=%0d y=%0d",
                   tg, tt, ac.hs, ac.vs, ac.de, ac.bf, ac.ls, ac.fs, ac.px, ac.py,
                   ex.hs, ex.vs, ex.de, ex.bf, ex.ls, ex.fs, ex.px, ex.py);
        end
      end
    end
  end

  initial begin
    rst_i         = 1'b1;
    enable_i      = 1'b0;
    force_black_i = 1'b0;
    run_n(3,   1'b1, 1'b0, 1'b0, "reset");
    run_n(10,  1'b0, 1'b0, 1'b0, "idle");
    run_n(528, 1'b0, 1'b1, 1'b0, "warmup_and_run");
    run_n(192, 1'b0, 1'b1, 1'b1, "force_black_rise");
    run_n(150, 1'b0, 1'b1, 1'b0, "force_black_fall");
    run_n(1,   1'b0, 1'b0, 1'b0, "enable_drop");
    run_n(5,   1'b0, 1'b0, 1'b0, "idle_after_drop");
    run_n(340, 1'b0, 1'b1, 1'b0, "reenable_warmup");
    run_n(1,   1'b1, 1'b1, 1'b0, "rst_abort");
    run_n(300, 1'b0, 1'b1, 1'b1, "warmup_ignores_fb");
    run_n(40,  1'b0, 1'b1, 1'b0, "run_after_rst");
    @(negedge clk);
    @(negedge clk);
    total++;
    if (fs_seen != 12) begin
      bad++;
      $display("FAIL frame_start_count got=%0d want=12", fs_seen);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
